// File: rtl/dtw_core_ref_banked_pkg.sv
// Shared encodings for the banked DTW reference memory controller:
// operation codes driven on op_mode_in and the controller FSM states.
package dtw_ref_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'd0,
        OP_LOAD_ONE   = 2'd1,
        OP_LOAD_ALL   = 2'd2,
        OP_CLEAR_DONE = 2'd3
    } op_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ref_state_e;

endpackage

// File: rtl/dtw_core_ref_banked_mem.sv
// Single-port reference sample memory, read-first, one-cycle registered read.
// The read register comes out of reset holding the initalize value.
module dtw_core_ref_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PTR_WIDTH  = 20,
    parameter int          initalize  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wren_i,
    input  logic [PTR_WIDTH-1:0]  addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << PTR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wren_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= DATA_WIDTH'(initalize);
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dtw_core_ref_banked.sv
// Banked reference memory controller: loads one bank or all banks from the
// shared FWFT source FIFO while unselected banks keep serving their readers.
module dtw_core_ref_banked
    import dtw_ref_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 16,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned REFMEM_PTR_WIDTH = 20,
    parameter int unsigned NUM_BANKS        = 4,
    parameter int unsigned BANK_SEL_WIDTH   = 2,
    parameter int          REF_INIT         = 0
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   rs_in,
    input  logic [1:0]                             op_mode_in,
    input  logic [BANK_SEL_WIDTH-1:0]              bank_sel_in,
    input  logic [ADDR_WIDTH-1:0]                  ref_len_in,
    output logic                                   busy_out,
    output logic [NUM_BANKS-1:0]                   ref_load_done_out,
    output logic                                   len_err_out,
    output logic                                   src_fifo_clear_out,
    output logic                                   src_fifo_rden_out,
    input  logic                                   src_fifo_empty_in,
    input  logic [DATA_WIDTH-1:0]                  src_fifo_data_in,
    input  logic [NUM_BANKS*REFMEM_PTR_WIDTH-1:0]  ref_addr_in,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]        ref_data_out,
    output logic [1:0]                             dbg_state,
    output logic [31:0]                            dbg_addr_ref,
    output logic [NUM_BANKS-1:0]                   dbg_wren_ref
);

    // Counters are one bit wider than the bank pointer so a full-depth load
    // can be counted without wrapping.
    localparam int unsigned LEN_W = REFMEM_PTR_WIDTH + 1;
    localparam logic [63:0] DEPTH = 64'd1 << REFMEM_PTR_WIDTH;

    ref_state_e                state_q, state_d;
    logic [NUM_BANKS-1:0]      mask_q, mask_d;
    logic [NUM_BANKS-1:0]      done_q, done_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          cons_q, cons_d;
    logic [LEN_W-1:0]          wptr_q, wptr_d;
    logic                      wr_pend_q, wr_pend_d;
    logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
    logic                      len_err_q, len_err_d;
    logic                      clr_q, clr_d;

    op_mode_e                  op;
    logic                      bank_ok;
    logic [NUM_BANKS-1:0]      sel_mask;
    logic [NUM_BANKS-1:0]      tgt;
    logic                      len_ok;
    logic                      rden;
    logic                      fire;
    logic                      abort;
    logic                      wr_fire;
    logic [NUM_BANKS-1:0]      wren;

    always_comb begin
        op       = op_mode_e'(op_mode_in);
        bank_ok  = 32'(bank_sel_in) < NUM_BANKS;
        sel_mask = bank_ok ? (NUM_BANKS'(1) << bank_sel_in) : '0;
        len_ok   = (ref_len_in != '0) && (64'(ref_len_in) <= DEPTH);
        rden     = (state_q == ST_LOAD) && (cons_q < len_q);
        fire     = rden && !src_fifo_empty_in;
        abort    = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !rs_in;
        // A write still in the pipe when the run is stopped is dropped.
        wr_fire  = wr_pend_q && !abort;
        wren     = mask_q & {NUM_BANKS{wr_fire}};
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        done_d    = done_q;
        len_d     = len_q;
        cons_d    = cons_q;
        wptr_d    = wptr_q;
        wr_pend_d = 1'b0;
        wr_data_d = wr_data_q;
        len_err_d = len_err_q;
        clr_d     = (state_q == ST_IDLE) && !rs_in;
        tgt       = '0;

        if (wr_fire) begin
            wptr_d = wptr_q + LEN_W'(1);
        end
        if (fire) begin
            wr_pend_d = 1'b1;
            wr_data_d = src_fifo_data_in;
            cons_d    = cons_q + LEN_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (rs_in) begin
                    case (op)
                        OP_LOAD_ONE, OP_LOAD_ALL: begin
                            tgt = (op == OP_LOAD_ALL) ? '1 : sel_mask;
                            if (tgt != '0) begin
                                if (!len_ok) begin
                                    len_err_d = 1'b1;
                                end else if ((done_q & tgt) == '0) begin
                                    mask_d  = tgt;
                                    len_d   = LEN_W'(ref_len_in);
                                    cons_d  = '0;
                                    wptr_d  = '0;
                                    state_d = ST_LOAD;
                                end
                            end
                        end
                        OP_CLEAR_DONE: begin
                            if (bank_ok) begin
                                done_d    = done_q & ~sel_mask;
                                len_err_d = 1'b0;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    wr_pend_d = 1'b0;
                    clr_d     = 1'b1;
                end else if (fire && (cons_q + LEN_W'(1) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last consumed word is written during the single DRAIN cycle.
                if (abort) begin
                    state_d   = ST_IDLE;
                    wr_pend_d = 1'b0;
                    clr_d     = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d  = done_q | mask_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            done_q    <= '0;
            len_q     <= '0;
            cons_q    <= '0;
            wptr_q    <= '0;
            wr_pend_q <= 1'b0;
            wr_data_q <= '0;
            len_err_q <= 1'b0;
            clr_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            done_q    <= done_d;
            len_q     <= len_d;
            cons_q    <= cons_d;
            wptr_q    <= wptr_d;
            wr_pend_q <= wr_pend_d;
            wr_data_q <= wr_data_d;
            len_err_q <= len_err_d;
            clr_q     <= clr_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [REFMEM_PTR_WIDTH-1:0] raddr;

        // A loading bank has its single port stolen by the write pointer.
        assign raddr = (mask_q[b] && wr_pend_q) ? wptr_q[REFMEM_PTR_WIDTH-1:0]
                                                : ref_addr_in[b*REFMEM_PTR_WIDTH +: REFMEM_PTR_WIDTH];

        dtw_core_ref_mem #(
            .DATA_WIDTH (DATA_WIDTH),
            .PTR_WIDTH  (REFMEM_PTR_WIDTH),
            .initalize  (REF_INIT)
        ) u_mem (
            .clk_i   (clk_in),
            .rst_i   (rst_in),
            .wren_i  (wren[b]),
            .addr_i  (raddr),
            .wdata_i (wr_data_q),
            .rdata_o (ref_data_out[b*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign busy_out           = (state_q != ST_IDLE);
    assign ref_load_done_out  = done_q;
    assign len_err_out        = len_err_q;
    assign src_fifo_clear_out = clr_q;
    assign src_fifo_rden_out  = rden;
    assign dbg_state          = state_q;
    assign dbg_addr_ref       = 32'(wptr_q);
    assign dbg_wren_ref       = wren;

endmodule

// File: tb/tb_dtw_core_ref_banked.sv
// Scoreboard bench for dtw_core_ref_banked: expected bank writes and read
// data are queued by the stimulus and consumed by a negedge monitor.
module tb_dtw_core_ref_banked;
    import dtw_ref_pkg::*;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int PW = 20;
    localparam int NB = 4;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_in = 1'b1;
    logic              rs_in = 1'b0;
    logic [1:0]        op_mode = OP_READ;
    logic [BW-1:0]     bank_sel = '0;
    logic [AW-1:0]     ref_len = '0;
    logic              busy_out;
    logic [NB-1:0]     done_out;
    logic              len_err_out;
    logic              clear_out;
    logic              rden_out;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_data;
    logic [NB*PW-1:0]  ref_addr = '0;
    logic [NB*DW-1:0]  ref_data;
    logic [1:0]        dbg_state;
    logic [31:0]       dbg_addr_ref;
    logic [NB-1:0]     dbg_wren_ref;

    dtw_core_ref_banked #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .REFMEM_PTR_WIDTH (PW),
        .NUM_BANKS        (NB),
        .BANK_SEL_WIDTH   (BW),
        .REF_INIT         (0)
    ) dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .rs_in              (rs_in),
        .op_mode_in         (op_mode),
        .bank_sel_in        (bank_sel),
        .ref_len_in         (ref_len),
        .busy_out           (busy_out),
        .ref_load_done_out  (done_out),
        .len_err_out        (len_err_out),
        .src_fifo_clear_out (clear_out),
        .src_fifo_rden_out  (rden_out),
        .src_fifo_empty_in  (fifo_empty),
        .src_fifo_data_in   (fifo_data),
        .ref_addr_in        (ref_addr),
        .ref_data_out       (ref_data),
        .dbg_state          (dbg_state),
        .dbg_addr_ref       (dbg_addr_ref),
        .dbg_wren_ref       (dbg_wren_ref)
    );

    // FWFT source FIFO model; cleared whenever the DUT asks for it.
    logic [DW-1:0] fifo_mem [64];
    int unsigned   fifo_wr = 0;
    int unsigned   fifo_rd = 0;
    logic          stall = 1'b0;

    assign fifo_empty = (fifo_rd == fifo_wr) || stall;
    assign fifo_data  = fifo_mem[fifo_rd[5:0]];

    always @(posedge clk) begin
        if (clear_out) fifo_rd <= fifo_wr;
        else if (rden_out && !fifo_empty) fifo_rd <= fifo_rd + 1;
    end

    typedef struct packed {
        logic [NB-1:0] mask;
        logic [31:0]   addr;
    } wexp_t;

    typedef struct {
        int unsigned   bank;
        logic [DW-1:0] data;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    checks = 0;
    int    errors = 0;
    logic  rd_req = 1'b0;
    logic  rd_chk = 1'b0;
    wexp_t we;
    rexp_t re;

    always @(negedge clk) begin
        if (dbg_wren_ref != '0) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got wren=%b addr=%0d, required no write", dbg_wren_ref, dbg_addr_ref);
            end else begin
                we = wq.pop_front();
                if (we.mask !== dbg_wren_ref || we.addr !== dbg_addr_ref) begin
                    errors++;
                    $display("FAIL wr_txn: got wren=%b addr=%0d, required wren=%b addr=%0d",
                             dbg_wren_ref, dbg_addr_ref, we.mask, we.addr);
                end
            end
        end
        if (rd_chk) begin
            checks++;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rd_missing: no expected read data queued");
            end else begin
                re = rq.pop_front();
                if (ref_data[re.bank*DW +: DW] !== re.data) begin
                    errors++;
                    $display("FAIL rd_data bank%0d: got %0h required %0h",
                             re.bank, ref_data[re.bank*DW +: DW], re.data);
                end
            end
        end
        rd_chk = rd_req;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_words(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[fifo_wr[5:0]] = base + DW'(i);
            fifo_wr++;
        end
    endtask

    task automatic exp_writes(input logic [NB-1:0] mask, input int n);
        for (int i = 0; i < n; i++) wq.push_back('{mask: mask, addr: 32'(i)});
    endtask

    task automatic issue(input op_mode_e op, input int bank, input logic [AW-1:0] len);
        op_mode  = op;
        bank_sel = BW'(bank);
        ref_len  = len;
        cyc(1);
        op_mode  = OP_READ;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (dbg_state != ST_IDLE && n < maxc) begin
            cyc(1);
            n++;
        end
        chk("idle_timeout", 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic rd(input int bank, input logic [PW-1:0] addr, input logic [DW-1:0] exp);
        ref_addr[bank*PW +: PW] = addr;
        rq.push_back('{bank: bank, data: exp});
        rd_req = 1'b1;
        cyc(1);
        rd_req = 1'b0;
        cyc(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(busy_out), 0);
        chk({tag, "_done"}, 64'(done_out), 0);
        chk({tag, "_lenerr"}, 64'(len_err_out), 0);
        chk({tag, "_clear"}, 64'(clear_out), 1);
        chk({tag, "_wren"}, 64'(dbg_wren_ref), 0);
        chk({tag, "_state"}, 64'(dbg_state), 0);
        chk({tag, "_addr"}, 64'(dbg_addr_ref), 0);
        chk({tag, "_rden"}, 64'(rden_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk_reset_vals("reset");
        rst_in = 1'b0;
        rs_in  = 1'b1;
        cyc(2);
        chk("clear_run", 64'(clear_out), 0);

        // LOAD_ONE bank 1, four words
        fifo_mem[0] = 16'h11; fifo_mem[1] = 16'h22; fifo_mem[2] = 16'h33; fifo_mem[3] = 16'h44;
        fifo_wr = 4;
        exp_writes(4'b0010, 4);
        issue(OP_LOAD_ONE, 1, 32'd4);
        chk("t1_busy", 64'(busy_out), 1);
        wait_idle(50);
        chk("t1_done", 64'(done_out), 64'b0010);
        rd(1, 20'd2, 16'h33);
        rd(1, 20'd0, 16'h11);

        issue(OP_CLEAR_DONE, 1, 32'd0);
        chk("clr1_done", 64'(done_out), 0);

        // LOAD_ALL with a FIFO-empty stall after the first two words
        push_words(16'h000A, 4);
        exp_writes(4'b1111, 3);
        issue(OP_LOAD_ALL, 0, 32'd3);
        cyc(2);
        stall = 1'b1;
        cyc(1);
        chk("t2_stall_ptr_a", 64'(dbg_addr_ref), 2);
        cyc(1);
        chk("t2_stall_ptr_b", 64'(dbg_addr_ref), 2);
        chk("t2_stall_state", 64'(dbg_state), 64'(ST_LOAD));
        stall = 1'b0;
        wait_idle(50);
        chk("t2_done", 64'(done_out), 64'b1111);
        chk("t2_fifo_left", 64'(fifo_wr - fifo_rd), 1);
        rd(0, 20'd0, 16'h000A);
        rd(3, 20'd2, 16'h000C);
        rd(1, 20'd1, 16'h000B);

        // reload of a done bank is refused until its flag is cleared
        issue(OP_LOAD_ONE, 1, 32'd2);
        chk("t3_refused_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("t3_refused_rden", 64'(rden_out), 0);
        cyc(1);
        chk("t3_refused_fifo", 64'(fifo_wr - fifo_rd), 1);
        issue(OP_CLEAR_DONE, 1, 32'd0);
        chk("t3_clr_done", 64'(done_out), 64'b1101);
        push_words(16'h005B, 1);
        exp_writes(4'b0010, 2);
        issue(OP_LOAD_ONE, 1, 32'd2);
        wait_idle(50);
        chk("t3_done", 64'(done_out), 64'b1111);
        rd(1, 20'd0, 16'h000D);
        rd(1, 20'd1, 16'h005B);

        // preload bank 2, then read it every cycle while bank 0 loads
        issue(OP_CLEAR_DONE, 2, 32'd0);
        push_words(16'h0020, 6);
        exp_writes(4'b0100, 6);
        issue(OP_LOAD_ONE, 2, 32'd6);
        wait_idle(50);
        issue(OP_CLEAR_DONE, 0, 32'd0);
        chk("t4_pre_done", 64'(done_out), 64'b1110);
        push_words(16'h0030, 8);
        exp_writes(4'b0001, 8);
        ref_addr[2*PW +: PW] = 20'd5;
        op_mode  = OP_LOAD_ONE;
        bank_sel = 2'd0;
        ref_len  = 32'd8;
        for (int i = 0; i < 16; i++) begin
            rq.push_back('{bank: 2, data: 16'h0025});
            rd_req = 1'b1;
            cyc(1);
            op_mode = OP_READ;
        end
        rd_req = 1'b0;
        cyc(1);
        wait_idle(50);
        chk("t4_done", 64'(done_out), 64'b1111);
        rd(0, 20'd7, 16'h0037);

        // length errors and the full-depth boundary
        issue(OP_CLEAR_DONE, 3, 32'd0);
        issue(OP_LOAD_ONE, 3, 32'd0);
        chk("t5_len0_err", 64'(len_err_out), 1);
        chk("t5_len0_state", 64'(dbg_state), 64'(ST_IDLE));
        issue(OP_CLEAR_DONE, 3, 32'd0);
        chk("t5_clr_err", 64'(len_err_out), 0);
        issue(OP_LOAD_ALL, 0, (32'd1 << 20) + 32'd1);
        chk("t5_lenbig_err", 64'(len_err_out), 1);
        chk("t5_lenbig_state", 64'(dbg_state), 64'(ST_IDLE));
        issue(OP_CLEAR_DONE, 3, 32'd0);
        chk("t5_clr_err2", 64'(len_err_out), 0);
        issue(OP_LOAD_ONE, 3, 32'd1 << 20);
        chk("t5_fulldepth_state", 64'(dbg_state), 64'(ST_LOAD));
        chk("t5_fulldepth_err", 64'(len_err_out), 0);
        rs_in = 1'b0;
        cyc(1);
        chk("t5_abort_state", 64'(dbg_state), 64'(ST_IDLE));
        rs_in = 1'b1;
        cyc(2);

        // abort after three of eight words
        push_words(16'h0040, 8);
        exp_writes(4'b1000, 2);
        issue(OP_LOAD_ONE, 3, 32'd8);
        cyc(3);
        rs_in = 1'b0;
        cyc(1);
        chk("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("t6_busy", 64'(busy_out), 0);
        chk("t6_clear_pulse", 64'(clear_out), 1);
        chk("t6_done", 64'(done_out), 64'b0111);
        rs_in = 1'b1;
        cyc(1);
        chk("t6_clear_end", 64'(clear_out), 0);
        rd(3, 20'd1, 16'h0041);

        // reset in the middle of a load
        push_words(16'h0050, 8);
        exp_writes(4'b1000, 2);
        issue(OP_LOAD_ONE, 3, 32'd8);
        cyc(2);
        rst_in = 1'b1;
        cyc(1);
        chk_reset_vals("midrst");
        rst_in = 1'b0;
        cyc(2);

        chk("wq_drained", 64'(wq.size()), 0);
        chk("rq_drained", 64'(rq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtw_core_ref_banked.md
Name: dtw_core_ref_banked

Overview:
- Multi-bank reference memory controller for multi-accelerator DTW: NUM_BANKS independent reference memories, one read port per DTW core.
- Loads one selected bank, or broadcasts to all banks, from the shared source FIFO.
- Non-target banks keep serving reads while a load is in progress.
- Per-bank sticky load-done flags; explicit clear operation; length-error detection.

Parameters:
- DATA_WIDTH, 16, reference sample width
- ADDR_WIDTH, 32, AXI register width (ref_len_in, dbg_addr_ref)
- REFMEM_PTR_WIDTH, 20, per-bank address width; depth = 2**REFMEM_PTR_WIDTH
- NUM_BANKS, 4, number of banks / read ports (>=1)
- BANK_SEL_WIDTH, 2, width of bank_sel_in (>= clog2(NUM_BANKS), min 1)
- REF_INIT, 0, passed to every bank memory's initalize

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- rs_in  in  1  run(1)/stop(0)
- op_mode_in  in  2  0=READ, 1=LOAD_ONE, 2=LOAD_ALL, 3=CLEAR_DONE
- bank_sel_in  in  BANK_SEL_WIDTH  target bank for LOAD_ONE / CLEAR_DONE
- ref_len_in  in  ADDR_WIDTH  samples to load
- busy_out  out  1  load in progress
- ref_load_done_out  out  NUM_BANKS  sticky per-bank done flags
- len_err_out  out  1  sticky: rejected length
- src_fifo_clear_out  out  1  source FIFO clear
- src_fifo_rden_out  out  1  source FIFO read enable (FWFT)
- src_fifo_empty_in  in  1  source FIFO empty
- src_fifo_data_in  in  DATA_WIDTH  source FIFO head word
- ref_addr_in  in  NUM_BANKS*REFMEM_PTR_WIDTH  read addresses, bank b at slice b
- ref_data_out  out  NUM_BANKS*DATA_WIDTH  read data, bank b at slice b
- dbg_state  out  2  FSM state
- dbg_addr_ref  out  32  zero-extended write pointer
- dbg_wren_ref  out  NUM_BANKS  per-bank write enables

Behaviour:
- Reset (sync, active-high) -> state IDLE; busy_out=0, ref_load_done_out=0, len_err_out=0, src_fifo_clear_out=1, dbg_wren_ref=0, write pointer=0. Memory contents unaffected.
- FSM states: IDLE=0, LOAD=1, DRAIN=2, DONE=3.
- IDLE, rs_in=1:
  - LOAD_ONE/LOAD_ALL: start only if all target done bits are 0. Also requires 0 < ref_len_in <= 2**REFMEM_PTR_WIDTH; otherwise set len_err_out and stay IDLE.
  - On start: latch target mask (one-hot of bank_sel_in, or all ones), latch length; write pointer=0; -> LOAD.
  - bank_sel_in >= NUM_BANKS is ignored (no start, no clear).
  - CLEAR_DONE: clear done bit of bank_sel_in, and clear len_err_out, in one cycle; stay IDLE.
  - READ: no action.
- src_fifo_rden_out is combinational: (state==LOAD) && (consumed < len). A word is consumed when rden && !empty. src_fifo_data_in is valid in the same cycle (FWFT).
- Write pipeline, one register stage: a consumed word is written at the write pointer into every masked bank on the next cycle (dbg_wren_ref = mask during that cycle). The pointer increments after each write.
- LOAD -> DRAIN once consumed == len; DRAIN -> DONE once the last write has been issued; DONE sets done bits |= mask; DONE -> IDLE after 1 cycle.
- busy_out=1 in LOAD/DRAIN/DONE.
- src_fifo_clear_out registered: 1 in IDLE when rs_in=0, 0 otherwise. Also forced to 1 for one cycle on abort.
- Abort: rs_in falling to 0 in LOAD/DRAIN -> IDLE next cycle. Pending write is discarded, done bits unchanged (target stays 0).
- Read port b:
  - Address = write pointer when bank b is masked and a write is pending; otherwise ref_addr_in slice b.
  - 1-cycle read latency.
  - Read data of masked banks is undefined during LOAD/DRAIN/DONE; unmasked banks stay fully functional.
- A FIFO empty stall leaves pointer and state held indefinitely.
- Write pointer never wraps: length is capped at depth by the start check.

Decomposition:
- Shared package dtw_ref_pkg: op-mode codes (READ/LOAD_ONE/LOAD_ALL/CLEAR_DONE) and FSM state encodings, reused by the register block and testbench.
- Sub-module: the existing dtw_core_ref_mem, instantiated NUM_BANKS times via generate, one per bank.
- Controller FSM and write pipeline stay in this module.

Test Plan:
- Reset, then LOAD_ONE bank 1, len 4, FIFO 0x11,0x22,0x33,0x44 -> 4 writes at addr 0..3 with dbg_wren_ref=4'b0010; done=4'b0010; read bank1 addr 2 returns 0x33 one cycle later.
- LOAD_ALL len 3, data 0xA,0xB,0xC with empty asserted 2 cycles after the first word -> pointer holds during the stall; all banks hold 0xA,0xB,0xC; done=4'b1111; no extra rden after the 3rd word.
- Repeat LOAD_ONE bank 1 while done[1]=1 -> stays IDLE, no rden; then CLEAR_DONE bank 1, then load len 2 -> completes, done[1]=1.
- During a LOAD_ONE bank 0 len 8, bank 2 (preloaded) reads addr 5 every cycle -> correct data each cycle, uninterrupted.
- ref_len_in=0 and ref_len_in=2**20+1 -> len_err_out=1, stays IDLE; CLEAR_DONE clears it.
- rs_in dropped after 3 of 8 words -> IDLE next cycle, src_fifo_clear_out pulses, done bit stays 0; rst_in mid-load -> all outputs at reset values.
